// File: rtl/cpu_mem_responder.sv
// Dual-port word memory: fixed-latency instruction read port plus a load/store
// responder with byte enables. Define LDST_WAIT_EN to build the waitrequest FSM.
module cpu_mem_responder #(
  parameter int    IW          = 32,
  parameter int    DEPTH_WORDS = 4096,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] i_pc_addr,
  input  logic          i_pc_rd,
  input  logic [3:0]    i_pc_byte_en,
  output logic [IW-1:0] o_pc_rddata,
  input  logic [IW-1:0] i_ldst_addr,
  input  logic          i_ldst_rd,
  input  logic          i_ldst_wr,
  input  logic [IW-1:0] i_ldst_wrdata,
  input  logic [3:0]    i_ldst_byte_en,
  output logic [IW-1:0] o_ldst_rddata,
  output logic          o_ldst_waitrequest
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [IW-1:0] mem [DEPTH_WORDS];

  logic [AW-1:0] pc_idx, ls_idx;
  logic          ls_req, ls_accept, ls_wait;
  logic          acc_wr, acc_rd;
  logic [IW-1:0] pc_rddata_q, ld_rddata_q;
  logic          unused_ok;

  assign pc_idx = i_pc_addr[AW+1:2];
  assign ls_idx = i_ldst_addr[AW+1:2];
  assign ls_req = i_ldst_rd | i_ldst_wr;
  // Low address bits, upper address bits and the PC byte enables carry no meaning here.
  assign unused_ok = ^{i_pc_byte_en, i_pc_addr, i_ldst_addr};

`ifdef LDST_WAIT_EN
  typedef enum logic {S_IDLE, S_WAIT} state_e;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wait_c, accept_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_c   = 1'b0;
    accept_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ls_req) begin
          if (WAIT_CYCLES == 0) begin
            accept_c = 1'b1;
          end else begin
            wait_c  = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A withdrawn request abandons the transaction without touching memory.
        if (!ls_req) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          wait_c = 1'b1;
          cnt_d  = cnt_q - 4'd1;
        end else begin
          accept_c = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset gates both so waitrequest drops and no write lands while reset is held.
  assign ls_wait   = wait_c & ~reset;
  assign ls_accept = accept_c & ~reset;
`else
  assign ls_wait   = 1'b0;
  assign ls_accept = ls_req & ~reset;
`endif

  assign acc_wr = ls_accept & i_ldst_wr;
  assign acc_rd = ls_accept & i_ldst_rd & ~i_ldst_wr;

  always_ff @(posedge clk) begin
    if (acc_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (i_ldst_byte_en[b]) mem[ls_idx][8*b +: 8] <= i_ldst_wrdata[8*b +: 8];
      end
    end
  end

  // Both read registers sample the pre-write array, giving read-before-write on collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_rddata_q <= '0;
      ld_rddata_q <= '0;
    end else begin
      if (i_pc_rd) pc_rddata_q <= mem[pc_idx];
      if (acc_rd)  ld_rddata_q <= mem[ls_idx];
    end
  end

  assign o_pc_rddata        = pc_rddata_q;
  assign o_ldst_rddata      = ld_rddata_q;
  assign o_ldst_waitrequest = ls_wait;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomized self-checking bench for cpu_mem_responder against an array model.
module tb_cpu_mem_responder;
  localparam int WC = 2;
  localparam int DW = 4096;
`ifdef LDST_WAIT_EN
  localparam int EXP_WAIT = WC;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_pc_addr, o_pc_rddata;
  logic        i_pc_rd;
  logic [3:0]  i_pc_byte_en;
  logic [31:0] i_ldst_addr, i_ldst_wrdata, o_ldst_rddata;
  logic        i_ldst_rd, i_ldst_wr, o_ldst_waitrequest;
  logic [3:0]  i_ldst_byte_en;

  int tests = 0;
  int fails = 0;
  logic [31:0] mem_m [DW];
  logic [31:0] exp_rd;

  cpu_mem_responder #(.IW(32), .DEPTH_WORDS(DW), .WAIT_CYCLES(WC), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .i_pc_addr(i_pc_addr), .i_pc_rd(i_pc_rd), .i_pc_byte_en(i_pc_byte_en),
    .o_pc_rddata(o_pc_rddata),
    .i_ldst_addr(i_ldst_addr), .i_ldst_rd(i_ldst_rd), .i_ldst_wr(i_ldst_wr),
    .i_ldst_wrdata(i_ldst_wrdata), .i_ldst_byte_en(i_ldst_byte_en),
    .o_ldst_rddata(o_ldst_rddata), .o_ldst_waitrequest(o_ldst_waitrequest)
  );

  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DW);
  endfunction

  // Called just after a negedge; returns just after a later negedge with the
  // request removed, so a following call is back-to-back.
  task automatic do_ldst(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    int n;
    n = 0;
    i_ldst_addr = a; i_ldst_wrdata = d; i_ldst_byte_en = be;
    i_ldst_rd = rd; i_ldst_wr = wr;
    #1;
    while (o_ldst_waitrequest && n < 40) begin
      n++;
      @(negedge clk); #1;
    end
    tests++;
    if (n !== EXP_WAIT) begin
      fails++;
      $display("FAIL wait_cycles addr=%h got %0d expected %0d", a, n, EXP_WAIT);
    end
    @(negedge clk);
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_m[widx(a)][8*b +: 8] = d[8*b +: 8];
    end else if (rd) begin
      exp_rd = mem_m[widx(a)];
    end
    i_ldst_rd = 1'b0; i_ldst_wr = 1'b0;
    tests++;
    if (o_ldst_rddata !== exp_rd) begin
      fails++;
      $display("FAIL ldst_rddata rd=%b wr=%b addr=%h got %h expected %h", rd, wr, a, o_ldst_rddata, exp_rd);
    end
  endtask

  task automatic pc_read(input logic [31:0] a);
    i_pc_addr = a; i_pc_rd = 1'b1;
    @(negedge clk);
    i_pc_rd = 1'b0;
    tests++;
    if (o_pc_rddata !== mem_m[widx(a)]) begin
      fails++;
      $display("FAIL pc_rddata addr=%h got %h expected %h", a, o_pc_rddata, mem_m[widx(a)]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_pc_addr = '0; i_pc_rd = 1'b0; i_pc_byte_en = 4'h0;
    i_ldst_addr = '0; i_ldst_rd = 1'b0; i_ldst_wr = 1'b0;
    i_ldst_wrdata = '0; i_ldst_byte_en = 4'h0;
    exp_rd = '0;
    #12;
    tests++;
    if ({o_pc_rddata, o_ldst_rddata, o_ldst_waitrequest} !== 65'd0) begin
      fails++;
      $display("FAIL reset_outputs got pc=%h ld=%h wr=%b expected zeros", o_pc_rddata, o_ldst_rddata, o_ldst_waitrequest);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_init_fill();
    for (int i = 0; i <= 64; i++) do_ldst(1'b0, 1'b1, 32'(i * 4), $urandom(), 4'hF);
  endtask

  task automatic test_pc_consecutive();
    do_ldst(1'b0, 1'b1, 32'h0, 32'h00500093, 4'hF);
    do_ldst(1'b0, 1'b1, 32'h4, 32'h00A00113, 4'hF);
    i_pc_addr = 32'h0; i_pc_rd = 1'b1;
    @(negedge clk);
    i_pc_addr = 32'h4;
    tests++;
    if (o_pc_rddata !== 32'h00500093) begin
      fails++; $display("FAIL pc_seq0 got %h expected %h", o_pc_rddata, 32'h00500093);
    end
    @(negedge clk);
    i_pc_rd = 1'b0;
    tests++;
    if (o_pc_rddata !== 32'h00A00113) begin
      fails++; $display("FAIL pc_seq1 got %h expected %h", o_pc_rddata, 32'h00A00113);
    end
    @(negedge clk);
    tests++;
    if (o_pc_rddata !== 32'h00A00113) begin
      fails++; $display("FAIL pc_hold got %h expected %h", o_pc_rddata, 32'h00A00113);
    end
  endtask

  task automatic test_store_load();
    do_ldst(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    do_ldst(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    tests++;
    if (o_ldst_rddata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL store_load got %h expected %h", o_ldst_rddata, 32'hDEADBEEF);
    end
  endtask

  task automatic test_byte_en();
    do_ldst(1'b0, 1'b1, 32'h40, 32'h11223344, 4'hF);
    do_ldst(1'b0, 1'b1, 32'h40, 32'h000000AA, 4'h1);
    do_ldst(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    tests++;
    if (o_ldst_rddata !== 32'h112233AA) begin
      fails++; $display("FAIL byte_en0 got %h expected %h", o_ldst_rddata, 32'h112233AA);
    end
    do_ldst(1'b0, 1'b1, 32'h40, 32'h0000BB00, 4'h2);
    do_ldst(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    tests++;
    if (o_ldst_rddata !== 32'h1122BBAA) begin
      fails++; $display("FAIL byte_en1 got %h expected %h", o_ldst_rddata, 32'h1122BBAA);
    end
    // Both rd and wr: write only, read data keeps its last value.
    do_ldst(1'b1, 1'b1, 32'h40, 32'hCCCCCCCC, 4'h8);
    do_ldst(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    tests++;
    if (o_ldst_rddata !== 32'hCC22BBAA) begin
      fails++; $display("FAIL rd_wr_both got %h expected %h", o_ldst_rddata, 32'hCC22BBAA);
    end
  endtask

  task automatic test_collision();
    int n;
    n = 0;
    do_ldst(1'b0, 1'b1, 32'h8, 32'h0, 4'hF);
    i_ldst_addr = 32'h8; i_ldst_wrdata = 32'h12345678; i_ldst_byte_en = 4'hF;
    i_ldst_wr = 1'b1;
    #1;
    while (o_ldst_waitrequest && n < 40) begin
      n++;
      @(negedge clk); #1;
    end
    i_pc_addr = 32'h8; i_pc_rd = 1'b1;
    @(negedge clk);
    i_ldst_wr = 1'b0;
    mem_m[2] = 32'h12345678;
    tests++;
    if (o_pc_rddata !== 32'h0) begin
      fails++; $display("FAIL collision_old got %h expected %h", o_pc_rddata, 32'h0);
    end
    @(negedge clk);
    i_pc_rd = 1'b0;
    tests++;
    if (o_pc_rddata !== 32'h12345678) begin
      fails++; $display("FAIL collision_new got %h expected %h", o_pc_rddata, 32'h12345678);
    end
  endtask

  task automatic test_alias();
    do_ldst(1'b0, 1'b1, 32'h4000, 32'hA5A55A5A, 4'hF);
    do_ldst(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    tests++;
    if (o_ldst_rddata !== 32'hA5A55A5A) begin
      fails++; $display("FAIL alias_ldst got %h expected %h", o_ldst_rddata, 32'hA5A55A5A);
    end
    pc_read(32'hFFFF_C003);
  endtask

  task automatic test_reset_mid();
    do_ldst(1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 4'hF);
    pc_read(32'h200);
    i_ldst_addr = 32'h200; i_ldst_wrdata = 32'h55555555; i_ldst_byte_en = 4'hF;
    i_ldst_wr = 1'b1;
    if (EXP_WAIT > 0) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    tests++;
    if ({o_pc_rddata, o_ldst_rddata, o_ldst_waitrequest} !== 65'd0) begin
      fails++;
      $display("FAIL reset_mid got pc=%h ld=%h wr=%b expected zeros", o_pc_rddata, o_ldst_rddata, o_ldst_waitrequest);
    end
    @(negedge clk);
    i_ldst_wr = 1'b0;
    reset = 1'b0;
    exp_rd = '0;
    @(negedge clk);
    do_ldst(1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    tests++;
    if (o_ldst_rddata !== 32'hCAFEF00D) begin
      fails++; $display("FAIL reset_mid_mem got %h expected %h", o_ldst_rddata, 32'hCAFEF00D);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int kind;
    for (int i = 0; i < 80; i++) begin
      a = ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      kind = $urandom_range(0, 3);
      case (kind)
        0: do_ldst(1'b1, 1'b0, a, $urandom(), 4'($urandom()));
        1: do_ldst(1'b0, 1'b1, a, $urandom(), 4'($urandom()));
        2: do_ldst(1'b1, 1'b1, a, $urandom(), 4'($urandom()));
        default: pc_read(a);
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_init_fill();
    test_pc_consecutive();
    test_store_load();
    test_byte_en();
    test_collision();
    test_alias();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
